// File: rtl/mmio_ctrl_pkg.sv
// Shared constants for the MMIO controller: register addresses, unmapped-read value,
// default timing parameters and the address-to-register decode helper.
package mmio_ctrl_pkg;

    localparam int DBITS_DEF      = 16;
    localparam int DEB_CYCLES_DEF = 500000;
    localparam int CLK_PER_MS_DEF = 50000;

    localparam logic [15:0] MMIO_KDATA    = 16'hFFF0;
    localparam logic [15:0] MMIO_SDATA    = 16'hFFF2;
    localparam logic [15:0] MMIO_KSTAT    = 16'hFFF4;
    localparam logic [15:0] MMIO_TCNT     = 16'hFFF6;
    localparam logic [15:0] MMIO_HEXR     = 16'hFFF8;
    localparam logic [15:0] MMIO_LEDRR    = 16'hFFFA;
    localparam logic [15:0] MMIO_LEDGR    = 16'hFFFC;
    localparam logic [15:0] MMIO_UNMAPPED = 16'hFFFE;
    localparam logic [15:0] MMIO_DEAD     = 16'hDEAD;

    typedef enum logic [2:0] {
        REG_KDATA,
        REG_SDATA,
        REG_KSTAT,
        REG_TCNT,
        REG_HEXR,
        REG_LEDRR,
        REG_LEDGR,
        REG_NONE
    } mmio_reg_e;

    // Decodes on the word address, so odd byte addresses alias their even neighbour.
    function automatic mmio_reg_e mmio_decode(input logic [14:0] word_addr);
        mmio_reg_e sel;
        sel = REG_NONE;
        if (word_addr == MMIO_KDATA[15:1])      sel = REG_KDATA;
        else if (word_addr == MMIO_SDATA[15:1]) sel = REG_SDATA;
        else if (word_addr == MMIO_KSTAT[15:1]) sel = REG_KSTAT;
        else if (word_addr == MMIO_TCNT[15:1])  sel = REG_TCNT;
        else if (word_addr == MMIO_HEXR[15:1])  sel = REG_HEXR;
        else if (word_addr == MMIO_LEDRR[15:1]) sel = REG_LEDRR;
        else if (word_addr == MMIO_LEDGR[15:1]) sel = REG_LEDGR;
        return sel;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Hex digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Only compiled when MMIO_HEX_DECODE_EN is defined, since nothing else uses it.
`ifdef MMIO_HEX_DECODE_EN
module seg7_dec (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        case (digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule
`endif

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O block at 0xFFF0-0xFFFE: debounced keys, switches, key-press capture,
// LED/HEX output registers and a millisecond timer. MMIO_HEX_DECODE_EN selects hex-digit HEX decoding.
module mmio_ctrl
    import mmio_ctrl_pkg::*;
#(
    parameter int DBITS      = DBITS_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CLK_PER_MS = CLK_PER_MS_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DBITS-1:0] ADDR,
    input  logic [DBITS-1:0] WDATA,
    input  logic             WE,
    output logic             HIT,
    output logic [DBITS-1:0] RDATA,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG
);
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

`ifdef MMIO_HEX_DECODE_EN
    localparam logic [DBITS-1:0] HEXR_RST = '0;
`else
    localparam logic [DBITS-1:0] HEXR_RST = DBITS'(16'h007F);
`endif

    genvar gi;

    logic [3:0]            key_meta_reg, key_sync_reg, key_deb_reg, key_deb_next;
    logic [3:0]            deb_done, key_fall;
    logic [3:0][DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
    logic [9:0]            sw_meta_reg, sw_sync_reg;
    logic [3:0]            kstat_reg, kstat_next, kstat_clr;
    logic [PRE_W-1:0]      presc_reg;
    logic                  tick;
    logic [DBITS-1:0]      tcnt_reg, hexr_reg, ledr_reg, ledg_reg;
    logic                  wr_en;
    mmio_reg_e             reg_sel;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ADDR[0];
    assign HIT     = (ADDR[15:4] == 12'hFFF);
    assign reg_sel = mmio_decode(ADDR[15:1]);
    assign wr_en   = WE && HIT;

    // Per-key debounce: count while the synced input disagrees with the debounced value.
    for (gi = 0; gi < 4; gi++) begin : g_deb
        assign deb_done[gi] = (key_sync_reg[gi] != key_deb_reg[gi]) &&
                              (deb_cnt_reg[gi] == DEB_W'(DEB_CYCLES - 1));
        assign deb_cnt_next[gi] = ((key_sync_reg[gi] == key_deb_reg[gi]) || deb_done[gi]) ?
                                  '0 : deb_cnt_reg[gi] + DEB_W'(1);
    end

    assign key_deb_next = (key_deb_reg & ~deb_done) | (key_sync_reg & deb_done);
    assign key_fall     = deb_done & key_deb_reg;
    assign kstat_clr    = (wr_en && reg_sel == REG_KSTAT) ? WDATA[3:0] : 4'b0;
    assign kstat_next   = (kstat_reg & ~kstat_clr) | key_fall;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            key_meta_reg <= 4'hF;
            key_sync_reg <= 4'hF;
            key_deb_reg  <= 4'hF;
            deb_cnt_reg  <= '0;
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            kstat_reg    <= '0;
        end else begin
            key_meta_reg <= KEY;
            key_sync_reg <= key_meta_reg;
            key_deb_reg  <= key_deb_next;
            deb_cnt_reg  <= deb_cnt_next;
            sw_meta_reg  <= SW;
            sw_sync_reg  <= sw_meta_reg;
            kstat_reg    <= kstat_next;
        end
    end

    assign tick = (presc_reg == PRE_W'(CLK_PER_MS - 1));

    // A CPU write to TCNT beats a same-cycle tick and restarts the prescaler.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc_reg <= '0;
            tcnt_reg  <= '0;
            hexr_reg  <= HEXR_RST;
            ledr_reg  <= '0;
            ledg_reg  <= '0;
        end else begin
            if (wr_en && reg_sel == REG_TCNT) begin
                tcnt_reg  <= WDATA;
                presc_reg <= '0;
            end else if (tick) begin
                tcnt_reg  <= tcnt_reg + DBITS'(1);
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + PRE_W'(1);
            end
            if (wr_en && reg_sel == REG_HEXR)  hexr_reg <= WDATA;
            if (wr_en && reg_sel == REG_LEDRR) ledr_reg <= WDATA;
            if (wr_en && reg_sel == REG_LEDGR) ledg_reg <= WDATA;
        end
    end

    always_comb begin
        RDATA = '0;
        if (HIT) begin
            case (reg_sel)
                REG_KDATA: RDATA = {{(DBITS-4){1'b0}}, key_deb_reg};
                REG_SDATA: RDATA = {{(DBITS-10){1'b0}}, sw_sync_reg};
                REG_KSTAT: RDATA = {{(DBITS-4){1'b0}}, kstat_reg};
                REG_TCNT:  RDATA = tcnt_reg;
                REG_HEXR:  RDATA = hexr_reg;
                REG_LEDRR: RDATA = ledr_reg;
                REG_LEDGR: RDATA = ledg_reg;
                default:   RDATA = DBITS'(MMIO_DEAD);
            endcase
        end
    end

    assign LEDR = ledr_reg[9:0];
    assign LEDG = ledg_reg[7:0];

`ifdef MMIO_HEX_DECODE_EN
    logic [3:0][6:0] hex_seg;
    for (gi = 0; gi < 4; gi++) begin : g_hex
        seg7_dec u_seg7_dec (
            .digit (hexr_reg[4*gi +: 4]),
            .seg   (hex_seg[gi])
        );
    end
    assign HEX0 = hex_seg[0];
    assign HEX1 = hex_seg[1];
    assign HEX2 = hex_seg[2];
    assign HEX3 = hex_seg[3];
`else
    assign HEX0 = hexr_reg[6:0];
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
`endif

endmodule

// File: tb/tb_mmio_ctrl.sv
// Scoreboard bench for mmio_ctrl with short debounce/prescale settings; directed vectors.
module tb_mmio_ctrl;
    import mmio_ctrl_pkg::*;

    localparam int DEB = 4;
    localparam int CPM = 3;

    localparam int SEL_RD   = 0;
    localparam int SEL_HIT  = 1;
    localparam int SEL_LEDR = 2;
    localparam int SEL_LEDG = 3;
    localparam int SEL_HEX0 = 4;
    localparam int SEL_HEX1 = 5;
    localparam int SEL_HEX2 = 6;
    localparam int SEL_HEX3 = 7;

`ifdef MMIO_HEX_DECODE_EN
    localparam logic [15:0] HEX0_RST = 16'h0040;
    localparam logic [15:0] HEXR_RST = 16'h0000;
`else
    localparam logic [15:0] HEX0_RST = 16'h007F;
    localparam logic [15:0] HEXR_RST = 16'h007F;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        we = 1'b0;
    logic        hit;
    logic [15:0] rdata;
    logic [3:0]  key = 4'hF;
    logic [9:0]  sw = '0;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    always #5 clk = ~clk;

    mmio_ctrl #(
        .DBITS      (16),
        .DEB_CYCLES (DEB),
        .CLK_PER_MS (CPM)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .ADDR  (addr),
        .WDATA (wdata),
        .WE    (we),
        .HIT   (hit),
        .RDATA (rdata),
        .KEY   (key),
        .SW    (sw),
        .HEX0  (hex0),
        .HEX1  (hex1),
        .HEX2  (hex2),
        .HEX3  (hex3),
        .LEDR  (ledr),
        .LEDG  (ledg)
    );

    typedef struct {
        int          sel;
        logic [15:0] exp;
        string       tag;
    } chk_t;

    chk_t        sb_q[$];
    logic        chk_valid = 1'b0;
    logic        done = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    chk_t        mon_e;
    logic [15:0] mon_act;

    function automatic logic [15:0] pick(input int sel);
        case (sel)
            SEL_RD:   return rdata;
            SEL_HIT:  return {15'b0, hit};
            SEL_LEDR: return {6'b0, ledr};
            SEL_LEDG: return {8'b0, ledg};
            SEL_HEX0: return {9'b0, hex0};
            SEL_HEX1: return {9'b0, hex1};
            SEL_HEX2: return {9'b0, hex2};
            default:  return {9'b0, hex3};
        endcase
    endfunction

    // Monitor: pops an expectation whenever the stimulus side presents a sample window.
    always @(negedge clk) begin
        if (chk_valid) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_underflow: got sample with no expectation queued");
            end else begin
                mon_e   = sb_q.pop_front();
                mon_act = pick(mon_e.sel);
                if (mon_act !== mon_e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %h, expected %h", mon_e.tag, mon_act, mon_e.exp);
                end else begin
                    $display("ok   %s: %h", mon_e.tag, mon_act);
                end
            end
        end
        if (done) begin
            if (sb_q.size() != 0) begin
                miscompares++;
                $display("FAIL scoreboard_leftover: got %0d unchecked, expected 0", sb_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input int sel, input logic [15:0] a, input logic [15:0] exp, input string tag);
        chk_t e;
        addr = a;
        we   = 1'b0;
        e.sel = sel;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
        chk_valid = 1'b1;
        @(negedge clk);
        #1;
        chk_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        cyc(2);
        // Reset state while reset is held
        chk(SEL_RD,   MMIO_TCNT,  16'h0000, "rst_tcnt");
        chk(SEL_RD,   MMIO_KDATA, 16'h000F, "rst_kdata");
        chk(SEL_RD,   MMIO_KSTAT, 16'h0000, "rst_kstat");
        chk(SEL_LEDR, 16'h0000,   16'h0000, "rst_ledr");
        chk(SEL_HEX0, 16'h0000,   HEX0_RST, "rst_hex0");
        chk(SEL_RD,   MMIO_HEXR,  HEXR_RST, "rst_hexr");
        rst = 1'b0;
        cyc(2);

        // Short glitch on KEY[1] is filtered; a long press is captured after 2+DEB cycles
        key = 4'b1101;
        cyc(3);
        key = 4'hF;
        cyc(8);
        chk(SEL_RD, MMIO_KSTAT, 16'h0000, "glitch_kstat");
        chk(SEL_RD, MMIO_KDATA, 16'h000F, "glitch_kdata");
        key = 4'b1101;
        cyc(5);
        chk(SEL_RD, MMIO_KDATA, 16'h000F, "deb_kdata_early");
        chk(SEL_RD, MMIO_KDATA, 16'h000D, "deb_kdata");
        chk(SEL_RD, MMIO_KSTAT, 16'h0002, "deb_kstat");

        // Set beats a same-cycle write-1-clear; a lone write-1-clear clears
        key = 4'hF;
        cyc(8);
        chk(SEL_RD, MMIO_KDATA, 16'h000F, "rel_kdata");
        chk(SEL_RD, MMIO_KSTAT, 16'h0002, "rel_kstat");
        key = 4'b1101;
        cyc(5);
        wr(MMIO_KSTAT, 16'h0002);
        chk(SEL_RD, MMIO_KSTAT, 16'h0002, "kstat_set_wins");
        wr(MMIO_KSTAT, 16'h0002);
        chk(SEL_RD, MMIO_KSTAT, 16'h0000, "kstat_w1c");
        key = 4'hF;
        cyc(8);

        // Timer wrap and write-over-tick priority
        wr(MMIO_TCNT, 16'hFFFF);
        chk(SEL_RD, MMIO_TCNT, 16'hFFFF, "tcnt_wr");
        chk(SEL_RD, MMIO_TCNT, 16'hFFFF, "tcnt_p1");
        chk(SEL_RD, MMIO_TCNT, 16'hFFFF, "tcnt_p2");
        chk(SEL_RD, MMIO_TCNT, 16'h0000, "tcnt_wrap");
        cyc(1);
        wr(MMIO_TCNT, 16'h0005);
        chk(SEL_RD, MMIO_TCNT, 16'h0005, "tcnt_wr_on_tick");
        chk(SEL_RD, MMIO_TCNT, 16'h0005, "tcnt_hold1");
        chk(SEL_RD, MMIO_TCNT, 16'h0005, "tcnt_hold2");
        chk(SEL_RD, MMIO_TCNT, 16'h0006, "tcnt_tick");

        // Output registers
        wr(MMIO_LEDRR, 16'h03FF);
        wr(MMIO_LEDGR, 16'h00AA);
        wr(MMIO_HEXR,  16'h1234);
        chk(SEL_LEDR, 16'h0000,   16'h03FF, "ledr_pins");
        chk(SEL_LEDG, 16'h0000,   16'h00AA, "ledg_pins");
        chk(SEL_RD,   16'hFFF9,   16'h1234, "hexr_odd_addr");
        chk(SEL_RD,   MMIO_LEDRR, 16'h03FF, "ledrr_read");
`ifdef MMIO_HEX_DECODE_EN
        chk(SEL_HEX3, 16'h0000, 16'h0079, "hex3_dec");
        chk(SEL_HEX2, 16'h0000, 16'h0024, "hex2_dec");
        chk(SEL_HEX1, 16'h0000, 16'h0030, "hex1_dec");
        chk(SEL_HEX0, 16'h0000, 16'h0019, "hex0_dec");
`else
        chk(SEL_HEX0, 16'h0000, 16'h0034, "hex0_raw");
        chk(SEL_HEX1, 16'h0000, 16'h007F, "hex1_blank");
        chk(SEL_HEX3, 16'h0000, 16'h007F, "hex3_blank");
`endif

        // Unmapped, miss and read-only behaviour; switch latency
        wr(MMIO_UNMAPPED, 16'h1234);
        chk(SEL_RD,  MMIO_UNMAPPED, 16'hDEAD, "unmapped_read");
        chk(SEL_HIT, 16'h0200,      16'h0000, "miss_hit");
        chk(SEL_RD,  16'h0200,      16'h0000, "miss_rdata");
        chk(SEL_HIT, MMIO_KDATA,    16'h0001, "hit_fff0");
        sw = 10'h2A5;
        chk(SEL_RD, MMIO_SDATA, 16'h0000, "sw_lat0");
        chk(SEL_RD, MMIO_SDATA, 16'h0000, "sw_lat1");
        chk(SEL_RD, MMIO_SDATA, 16'h02A5, "sw_lat2");
        wr(MMIO_SDATA, 16'hFFFF);
        chk(SEL_RD, MMIO_SDATA, 16'h02A5, "sdata_ro");

        // Mid-run asynchronous reset with captured key, partial debounce and live timer
        key = 4'b1110;
        cyc(8);
        chk(SEL_RD, MMIO_KSTAT, 16'h0001, "pre_rst_kstat");
        key = 4'b1011;
        cyc(2);
        rst = 1'b1;
        chk(SEL_LEDR, 16'h0000,   16'h0000, "mid_rst_ledr");
        chk(SEL_RD,   MMIO_KDATA, 16'h000F, "mid_rst_kdata");
        chk(SEL_RD,   MMIO_KSTAT, 16'h0000, "mid_rst_kstat");
        chk(SEL_RD,   MMIO_TCNT,  16'h0000, "mid_rst_tcnt");
        chk(SEL_LEDG, 16'h0000,   16'h0000, "mid_rst_ledg");
        chk(SEL_HEX0, 16'h0000,   HEX0_RST, "mid_rst_hex0");
        rst = 1'b0;
        cyc(5);
        chk(SEL_RD, MMIO_KDATA, 16'h000F, "post_rst_kdata_early");
        chk(SEL_RD, MMIO_KDATA, 16'h000B, "post_rst_kdata");

        done = 1'b1;
    end

endmodule
